// File: rtl/alu_control_seq.sv
// ALU control sequencer: handshake-accepted funct decode, one-hot unit select and multi-cycle MUL/DIV timing.
// Optional macro ALUCTL_DIV_EN builds the DIV_RUN path; without it DIV decodes as illegal.
module alu_control_seq #(
  parameter int FUNCT_W    = 6,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [FUNCT_W-1:0] funct,
  output logic               ready_out,
  output logic [FUNCT_W-1:0] op_out,
  output logic [3:0]         unit_sel,
  output logic               busy,
  output logic               hilo_wen,
  output logic               done,
  output logic               illegal
);

  localparam logic [FUNCT_W-1:0] F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] F_MUL   = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] F_MFLO  = FUNCT_W'(6'b010010);
  localparam logic [FUNCT_W-1:0] F_HILO  = {FUNCT_W{1'b1}};
  localparam logic [CNT_W-1:0]   MUL_LAST = CNT_W'(MUL_CYCLES);
`ifdef ALUCTL_DIV_EN
  localparam logic [FUNCT_W-1:0] F_DIV    = FUNCT_W'(6'b011011);
  localparam logic [CNT_W-1:0]   DIV_LAST = CNT_W'(DIV_CYCLES);
`endif

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;

  // The counter must reach the latency value without wrapping.
  if (MUL_CYCLES < 1 || DIV_CYCLES < 1 || (2 ** CNT_W) <= MAX_CYC) begin : g_param_err
    $error("alu_control_seq: illegal latency/counter parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_HILO_WR} state_t;

  state_t             r_state, w_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [FUNCT_W-1:0] r_op, w_op;
  logic [3:0]         r_sel, w_sel;
  logic               r_busy, w_busy;
  logic               r_hilo, w_hilo;
  logic               r_done, w_done;
  logic               r_illegal, w_illegal;
  logic               w_accept;
  logic [3:0]         w_dec;

  // Single-cycle unit decode; zero means not a single-cycle op.
  function automatic logic [3:0] decode_unit(input logic [FUNCT_W-1:0] f);
    logic [3:0] sel;
    sel = 4'b0000;
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT: sel = 4'b0001;
      F_SLL:                            sel = 4'b0010;
      F_MFHI, F_MFLO:                   sel = 4'b1000;
      default:                          sel = 4'b0000;
    endcase
    return sel;
  endfunction

  assign w_accept = valid_in && !r_busy;
  assign w_dec    = decode_unit(funct);

  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_op      = r_op;
    w_sel     = r_sel;
    w_busy    = r_busy;
    w_hilo    = 1'b0;
    w_done    = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_op  = '0;
        w_sel = 4'b0000;
        if (w_accept) begin
          if (funct == F_MUL) begin
            w_op    = F_MUL;
            w_sel   = 4'b0100;
            w_cnt   = CNT_W'(1);
            w_busy  = 1'b1;
            w_state = S_MUL_RUN;
          end
`ifdef ALUCTL_DIV_EN
          else if (funct == F_DIV) begin
            w_op    = F_DIV;
            w_sel   = 4'b0100;
            w_cnt   = CNT_W'(1);
            w_busy  = 1'b1;
            w_state = S_DIV_RUN;
          end
`endif
          else if (w_dec != 4'b0000) begin
            w_op   = funct;
            w_sel  = w_dec;
            w_done = 1'b1;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_MUL_RUN: begin
        if (r_cnt == MUL_LAST) begin
          w_state = S_HILO_WR;
          w_op    = F_HILO;
          w_hilo  = 1'b1;
          w_done  = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`ifdef ALUCTL_DIV_EN
      S_DIV_RUN: begin
        if (r_cnt == DIV_LAST) begin
          w_state = S_HILO_WR;
          w_op    = F_HILO;
          w_hilo  = 1'b1;
          w_done  = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_HILO_WR: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_op    = '0;
        w_sel   = 4'b0000;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_op    = '0;
        w_sel   = 4'b0000;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      r_sel     <= 4'b0000;
      r_busy    <= 1'b0;
      r_hilo    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_op      <= w_op;
      r_sel     <= w_sel;
      r_busy    <= w_busy;
      r_hilo    <= w_hilo;
      r_done    <= w_done;
      r_illegal <= w_illegal;
    end
  end

  assign ready_out = ~r_busy;
  assign op_out    = r_op;
  assign unit_sel  = r_sel;
  assign busy      = r_busy;
  assign hilo_wen  = r_hilo;
  assign done      = r_done;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: vector table for single-cycle decode plus MUL/DIV/reset sequences.
module tb_alu_control_seq;

  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] AND_ = 6'b100100;
  localparam logic [5:0] OR_  = 6'b100101;
  localparam logic [5:0] SLT  = 6'b101010;
  localparam logic [5:0] SLL  = 6'b000000;
  localparam logic [5:0] MFHI = 6'b010000;
  localparam logic [5:0] MFLO = 6'b010010;
  localparam logic [5:0] MUL  = 6'b011001;
  localparam logic [5:0] DIV  = 6'b011011;
  localparam logic [5:0] HILO = 6'b111111;

  logic       clk, rst;
  logic       v, v1;
  logic [5:0] f, f1;
  logic       rdy, bsy, hw, dn, il;
  logic [5:0] op;
  logic [3:0] sel;
  logic       rdy1, bsy1, hw1, dn1, il1;
  logic [5:0] op1;
  logic [3:0] sel1;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_seq #(.FUNCT_W(6), .MUL_CYCLES(32), .DIV_CYCLES(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .valid_in(v), .funct(f), .ready_out(rdy), .op_out(op),
    .unit_sel(sel), .busy(bsy), .hilo_wen(hw), .done(dn), .illegal(il)
  );

  alu_control_seq #(.FUNCT_W(6), .MUL_CYCLES(1), .DIV_CYCLES(1), .CNT_W(7)) dut1 (
    .clk(clk), .rst(rst), .valid_in(v1), .funct(f1), .ready_out(rdy1), .op_out(op1),
    .unit_sel(sel1), .busy(bsy1), .hilo_wen(hw1), .done(dn1), .illegal(il1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       v;
    logic [5:0] f;
    logic [5:0] op;
    logic [3:0] sel;
    logic       done;
    logic       ill;
  } vec_t;

  vec_t tbl[$];

  // Packed view: {op, sel, busy, hilo_wen, done, illegal, ready}
  function automatic logic [14:0] pk(input logic [5:0] o, input logic [3:0] s, input logic b,
                                     input logic h, input logic d, input logic i, input logic r);
    return {o, s, b, h, d, i, r};
  endfunction

  function automatic logic [14:0] snap0();
    return pk(op, sel, bsy, hw, dn, il, rdy);
  endfunction

  function automatic logic [14:0] snap1();
    return pk(op1, sel1, bsy1, hw1, dn1, il1, rdy1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int low;
    int seen;
    rst = 1'b1; v = 1'b0; f = '0; v1 = 1'b0; f1 = '0;

    tbl.push_back('{1'b1, ADD,     ADD,  4'b0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, SUB,     SUB,  4'b0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, SLL,     SLL,  4'b0010, 1'b1, 1'b0});
    tbl.push_back('{1'b1, MFHI,    MFHI, 4'b1000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, AND_,    AND_, 4'b0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, OR_,     OR_,  4'b0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, SLT,     SLT,  4'b0001, 1'b1, 1'b0});
    tbl.push_back('{1'b1, MFLO,    MFLO, 4'b1000, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 6'b111000, 6'b000000, 4'b0000, 1'b0, 1'b1});
    tbl.push_back('{1'b0, ADD,     6'b000000, 4'b0000, 1'b0, 1'b0});
`ifndef ALUCTL_DIV_EN
    tbl.push_back('{1'b1, DIV,     6'b000000, 4'b0000, 1'b0, 1'b1});
`endif
    tbl.push_back('{1'b0, 6'b000000, 6'b000000, 4'b0000, 1'b0, 1'b0});

    #12;
    chk("reset_dut", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    chk("reset_dut1", snap1(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i].v;
      f = tbl[i].f;
      tick();
      chk($sformatf("vec%0d_f%b", i, tbl[i].f), snap0(),
          pk(tbl[i].op, tbl[i].sel, 0, 0, tbl[i].done, tbl[i].ill, 1));
    end
    v = 1'b0;

    // Asynchronous reset between clock edges
    v = 1'b1; f = ADD;
    tick();
    chk("add_before_rst", snap0(), pk(ADD, 4'b0001, 0, 0, 1, 0, 1));
    v = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_midcycle", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;

    // MUL with 32-cycle latency; ADD held on the inputs must be ignored while busy
    v = 1'b1; f = MUL;
    tick();
    f = ADD;
    low = (rdy == 1'b0) ? 1 : 0;
    chk("mul_accept", snap0(), pk(MUL, 4'b0100, 1, 0, 0, 0, 0));
    for (int k = 1; k < 32; k++) begin
      tick();
      if (rdy == 1'b0) low++;
      chk($sformatf("mul_run%0d", k), snap0(), pk(MUL, 4'b0100, 1, 0, 0, 0, 0));
    end
    tick();
    if (rdy == 1'b0) low++;
    chk("mul_hilo_wr", snap0(), pk(HILO, 4'b0100, 1, 1, 1, 0, 0));
    tick();
    chk("mul_back_idle", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    chk("mul_ready_low_cycles", low, 33);
    tick();
    chk("add_after_mul", snap0(), pk(ADD, 4'b0001, 0, 0, 1, 0, 1));
    v = 1'b0;

    // Reset asserted during MUL_RUN with counter at 10
    v = 1'b1; f = MUL;
    tick();
    v = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_mul", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    repeat (2) tick();
    chk("rst_mid_mul_held", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (hw || bsy || dn) seen++;
    end
    chk("no_activity_after_rst", seen, 0);

    // MUL with single-cycle latency on the second instance
    v1 = 1'b1; f1 = MUL;
    tick();
    f1 = ADD;
    chk("mul1_accept", snap1(), pk(MUL, 4'b0100, 1, 0, 0, 0, 0));
    tick();
    chk("mul1_hilo_wr", snap1(), pk(HILO, 4'b0100, 1, 1, 1, 0, 0));
    tick();
    chk("mul1_idle", snap1(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
    tick();
    chk("mul1_next_accept", snap1(), pk(ADD, 4'b0001, 0, 0, 1, 0, 1));
    v1 = 1'b0;

`ifdef ALUCTL_DIV_EN
    v = 1'b1; f = DIV;
    tick();
    v = 1'b0;
    chk("div_accept", snap0(), pk(DIV, 4'b0100, 1, 0, 0, 0, 0));
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("div_run%0d", k), snap0(), pk(DIV, 4'b0100, 1, 0, 0, 0, 0));
    end
    tick();
    chk("div_hilo_wr", snap0(), pk(HILO, 4'b0100, 1, 1, 1, 0, 0));
    tick();
    chk("div_idle", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
`else
    v = 1'b1; f = DIV;
    tick();
    v = 1'b0;
    chk("div_disabled_illegal", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 1, 1));
    tick();
    chk("div_disabled_after", snap0(), pk(6'b0, 4'b0, 0, 0, 0, 0, 1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Parametrised successor to the single-funct ALU control decoder.
- Accepts a funct code through a valid/ready handshake and registers the code for the datapath.
- Decodes a one-hot target-unit select: ALU, shifter, multiplier, or HI/LO mux.
- Sequences multi-cycle MUL (and optionally DIV) with a configurable latency counter, a busy/ready stall, a HI/LO write-enable pulse and a done pulse.

Parameters:
- FUNCT_W, 6: width of funct and op_out.
- MUL_CYCLES, 32: cycles op_out holds MUL before the HI/LO write; must be ≥1.
- DIV_CYCLES, 32: cycles op_out holds DIV before the HI/LO write; must be ≥1. Used only with ALUCTL_DIV_EN.
- CNT_W, 7: latency counter width; must satisfy 2^CNT_W > max(MUL_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- valid_in  in  1  funct is presented this cycle.
- funct  in  FUNCT_W  operation code (R-type funct field).
- ready_out  out  1  block accepts a new op this cycle; equals ~busy.
- op_out  out  FUNCT_W  registered code to datapath units; 6'b111111 means HI/LO write.
- unit_sel  out  4  registered one-hot select: [0] ALU, [1] SHT, [2] MUL, [3] MUX.
- busy  out  1  multi-cycle op in progress.
- hilo_wen  out  1  one-cycle HI/LO register write strobe.
- done  out  1  one-cycle completion pulse.
- illegal  out  1  one-cycle pulse: accepted funct not recognised.

Behaviour:
- Codes:
  - AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010 → ALU.
  - SLL 000000 → SHT.
  - MUL 011001 → MUL.
  - MFHI 010000, MFLO 010010 → MUX.
  - DIV 011011 → MUL (only with ALUCTL_DIV_EN).
  - HILO_WR 111111 is internal only.
- Reset (async, immediate, including mid-operation):
  - state = IDLE, counter = 0.
  - op_out = 000000, unit_sel = 0000.
  - busy = hilo_wen = done = illegal = 0; ready_out = 1.
- Accept: valid_in && ready_out at a rising edge. Inputs are ignored while busy; there is no queueing.
- FSM states: IDLE, MUL_RUN, DIV_RUN, HILO_WR.
- IDLE, no accept:
  - op_out ← 000000, unit_sel ← 0000.
  - done, hilo_wen, illegal ← 0.
- IDLE, single-cycle op accepted:
  - op_out ← funct, unit_sel ← decode, done ← 1 (next cycle only).
  - Remain in IDLE, so back-to-back single-cycle ops run at one per clock.
- IDLE, unrecognised funct accepted:
  - op_out ← 000000, unit_sel ← 0000, illegal ← 1, done ← 0.
- IDLE, MUL accepted:
  - op_out ← MUL, unit_sel ← 0100, counter ← 1, busy ← 1, state ← MUL_RUN.
- MUL_RUN:
  - Hold op_out and unit_sel.
  - If counter == MUL_CYCLES: state ← HILO_WR, op_out ← 111111, hilo_wen ← 1, done ← 1, counter ← 0.
  - Otherwise counter ← counter + 1.
  - MUL_CYCLES = 1 goes straight to HILO_WR on the next edge.
- DIV_RUN: identical to MUL_RUN, using DIV_CYCLES and op DIV.
- HILO_WR (exactly one cycle; busy still 1):
  - Next edge: state ← IDLE, busy ← 0, hilo_wen ← 0, done ← 0, op_out ← 000000.
  - ready_out rises the cycle after HILO_WR.
- Total MUL occupancy: MUL_CYCLES + 1 cycles from the accept edge until ready_out is high again.
- Counter never wraps, by the CNT_W constraint.
- valid_in and funct may change freely while busy without effect.

Optional Feature:
- Macro ALUCTL_DIV_EN.
- Defined: DIV (011011) is a multi-cycle op through DIV_RUN with DIV_CYCLES latency, unit_sel 0100, followed by the HILO_WR cycle.
- Undefined: DIV_RUN is not built; DIV is treated as unrecognised (illegal pulse, op_out 000000, no busy).

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all outputs zero immediately, ready_out = 1. Repeat with rst asserted during MUL_RUN at counter = 10 → returns to IDLE, no hilo_wen.
- Back-to-back ADD, SUB, SLL, MFHI on consecutive cycles → next-cycle op_out = 100000, 100010, 000000, 010000; unit_sel = 0001, 0001, 0010, 1000; done high for 4 consecutive cycles.
- MUL with MUL_CYCLES = 32:
  - op_out = 011001 for 32 cycles after the accept edge.
  - Cycle 33: op_out = 111111 with hilo_wen = done = 1 for exactly one cycle.
  - ready_out = 0 for 33 cycles.
  - ADD presented during busy is ignored.
- MUL with MUL_CYCLES = 1 → one MUL cycle, then HILO_WR, then IDLE. Next op is accepted on the third edge.
- Illegal funct 111000 → illegal pulses once, op_out = 000000, busy stays 0.
- DIV 011011 with DIV_CYCLES = 8:
  - With ALUCTL_DIV_EN: 8 DIV cycles, then hilo_wen.
  - Without ALUCTL_DIV_EN: illegal pulse only.
